// File: rtl/svm_det_collect.sv
// Purpose : collect SVM detections (score > thresh) into a FWFT FIFO and keep per-frame count/max stats.
// Latency : a detection accepted at edge N is at the FIFO head in cycle N+1; frame stats land with frame_done one cycle after the last window.
// Backpr. : o_valid/o_ready handshake on the head; full with no pop drops the detection and sets sticky overflow.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_valid/i_result/i_sw_id   one SVM score per pulse with its window index
//   thresh              signed detection threshold (quasi-static)
//   clear               synchronous flush of FIFO, running stats and overflow
//   o_valid/o_ready/o_result/o_sw_id   FIFO head, first-word fall-through
//   frame_done          one-cycle pulse after the last window of a frame
//   det_cnt, best_*     statistics of the last completed frame
//   overflow            sticky, a qualified detection was dropped
module svm_det_collect #(
    parameter int FEA_I = 4,
    parameter int FEA_F = 28,
    parameter int SW_W  = 11,
    parameter int SW_N  = 1520,
    parameter int DEPTH = 16,
    localparam int RES_W = FEA_I + FEA_F
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [RES_W-1:0]    i_result,
    input  logic [SW_W-1:0]     i_sw_id,
    input  logic [RES_W-1:0]    thresh,
    input  logic                clear,
    input  logic                o_ready,
    output logic                o_valid,
    output logic [RES_W-1:0]    o_result,
    output logic [SW_W-1:0]     o_sw_id,
    output logic                frame_done,
    output logic [SW_W:0]       det_cnt,
    output logic                best_valid,
    output logic [RES_W-1:0]    best_result,
    output logic [SW_W-1:0]     best_sw_id,
    output logic                overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int ENT_W = RES_W + SW_W;
    localparam logic [SW_W-1:0] LAST_ID = SW_W'(SW_N - 1);

    // ------------------------------------------------------------------
    // Detection qualification
    // ------------------------------------------------------------------
    logic qual;
    logic frame_end;

    assign qual      = i_valid && ($signed(i_result) > $signed(thresh));
    assign frame_end = i_valid && (i_sw_id == LAST_ID);

    // ------------------------------------------------------------------
    // Detection FIFO: extra pointer MSB distinguishes full from empty
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             head_ok;
    logic [ENT_W-1:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Pop only when something is there, so an empty FIFO never bypasses.
    assign pop  = !fifo_empty && o_ready && !clear;
    assign push = qual && !clear && (!fifo_full || pop);
    assign drop = qual && !clear && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {i_result, i_sw_id};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            head_ok  <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                head_ok <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; the head reads as zero until the first write lands.
    assign head     = head_ok ? mem[rd_ptr[AW-1:0]] : '0;
    assign o_valid  = !fifo_empty;
    assign o_result = head[ENT_W-1:SW_W];
    assign o_sw_id  = head[SW_W-1:0];

    // ------------------------------------------------------------------
    // Per-frame running statistics (include dropped detections)
    // ------------------------------------------------------------------
    logic [SW_W:0]      run_cnt;
    logic               run_any;
    logic [RES_W-1:0]   run_max;
    logic [SW_W-1:0]    run_max_id;
    logic [SW_W:0]      cnt_n;
    logic               any_n;
    logic [RES_W-1:0]   max_n;
    logic [SW_W-1:0]    max_id_n;
    logic               max_upd;

    // Strictly greater keeps the earliest window on ties.
    assign max_upd = qual && (!run_any || ($signed(i_result) > $signed(run_max)));

    always_comb begin
        cnt_n    = run_cnt;
        any_n    = run_any;
        max_n    = run_max;
        max_id_n = run_max_id;
        if (qual) begin
            any_n = 1'b1;
            if (run_cnt != '1) begin
                cnt_n = run_cnt + 1'b1;
            end
        end
        if (max_upd) begin
            max_n    = i_result;
            max_id_n = i_sw_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt     <= '0;
            run_any     <= 1'b0;
            run_max     <= '0;
            run_max_id  <= '0;
            frame_done  <= 1'b0;
            det_cnt     <= '0;
            best_valid  <= 1'b0;
            best_result <= '0;
            best_sw_id  <= '0;
        end else if (clear) begin
            // Latched results of the last completed frame are kept.
            run_cnt    <= '0;
            run_any    <= 1'b0;
            run_max    <= '0;
            run_max_id <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                // Running max stays zero when nothing qualified, so the
                // latched best_* naturally read zero for an empty frame.
                det_cnt     <= cnt_n;
                best_valid  <= any_n;
                best_result <= max_n;
                best_sw_id  <= max_id_n;
                run_cnt     <= '0;
                run_any     <= 1'b0;
                run_max     <= '0;
                run_max_id  <= '0;
            end else begin
                run_cnt    <= cnt_n;
                run_any    <= any_n;
                run_max    <= max_n;
                run_max_id <= max_id_n;
            end
        end
    end

endmodule

// File: tb/tb_svm_det_collect.sv
// Directed bench for svm_det_collect: FIFO push/pop/overflow, frame statistics, clear and async reset.
module tb_svm_det_collect;

    localparam int RES_W = 32;
    localparam int SW_W  = 11;
    localparam int SW_N  = 1520;
    localparam int DEPTH = 16;

    logic               clk;
    logic               rst;
    logic               i_valid;
    logic [RES_W-1:0]   i_result;
    logic [SW_W-1:0]    i_sw_id;
    logic [RES_W-1:0]   thresh;
    logic               clear;
    logic               o_ready;
    logic               o_valid;
    logic [RES_W-1:0]   o_result;
    logic [SW_W-1:0]    o_sw_id;
    logic               frame_done;
    logic [SW_W:0]      det_cnt;
    logic               best_valid;
    logic [RES_W-1:0]   best_result;
    logic [SW_W-1:0]    best_sw_id;
    logic               overflow;

    int n_assert = 0;
    int n_fail   = 0;

    svm_det_collect #(
        .FEA_I(4), .FEA_F(28), .SW_W(SW_W), .SW_N(SW_N), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_result(i_result), .i_sw_id(i_sw_id),
        .thresh(thresh), .clear(clear), .o_ready(o_ready),
        .o_valid(o_valid), .o_result(o_result), .o_sw_id(o_sw_id),
        .frame_done(frame_done), .det_cnt(det_cnt), .best_valid(best_valid),
        .best_result(best_result), .best_sw_id(best_sw_id), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic win(input int score, input int id);
        i_valid  = 1'b1;
        i_result = RES_W'(score);
        i_sw_id  = SW_W'(id);
        step();
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_result = '0; i_sw_id = '0;
        thresh = '0; clear = 1'b0; o_ready = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_det_cnt", det_cnt, 0);
        chk("rst_best_valid", best_valid, 0);
        chk("rst_best_result", best_result, 0);
        chk("rst_best_sw_id", best_sw_id, 0);
        chk("rst_o_result", o_result, 0);
        chk("rst_o_sw_id", o_sw_id, 0);
        rst = 1'b1;
        step();

        // ---- single detection, then score equal to thresh ----
        o_ready = 1'b1;
        win(5, 3);
        chk("single_vld", o_valid, 1);
        chk("single_res", o_result, 5);
        chk("single_id", o_sw_id, 3);
        win(0, 4);
        chk("equal_no_push", o_valid, 0);
        win(-3, 5);
        chk("neg_no_push", o_valid, 0);
        i_valid = 1'b0;

        // ---- 17 detections into a stalled FIFO ----
        o_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            win(100 + k, k);
        end
        i_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        step();
        chk("stall_head_res", o_result, 100);
        chk("stall_head_id", o_sw_id, 0);
        o_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_vld", o_valid, 1);
            chk("drain_res", o_result, 64'(100 + k));
            chk("drain_id", o_sw_id, 64'(k));
            step();
        end
        chk("drain_empty", o_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // ---- clear with a qualified input ----
        clear = 1'b1;
        win(77, 7);
        clear = 1'b0; i_valid = 1'b0;
        chk("clr_empty", o_valid, 0);
        chk("clr_ovf", overflow, 0);
        step();
        chk("clr_no_push", o_valid, 0);

        // ---- full FIFO with simultaneous push and pop ----
        o_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            win(200 + k, k);
        end
        chk("full_no_ovf", overflow, 0);
        o_ready = 1'b1;
        win(300, 50);
        i_valid = 1'b0;
        o_ready = 1'b0;
        chk("pp_no_ovf", overflow, 0);
        chk("pp_head_res", o_result, 201);
        chk("pp_head_id", o_sw_id, 1);
        o_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            chk("pp_drain_res", o_result, 64'(200 + k));
            step();
        end
        chk("pp_last_vld", o_valid, 1);
        chk("pp_last_res", o_result, 300);
        chk("pp_last_id", o_sw_id, 50);
        step();
        chk("pp_empty", o_valid, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // ---- frame with 7@10, 9@20, 9@30, -1@40, 0@50 ----
        for (int w = 0; w < SW_N; w++) begin
            case (w)
                10:      win(7, w);
                20:      win(9, w);
                30:      win(9, w);
                40:      win(-1, w);
                50:      win(0, w);
                default: win(-5, w);
            endcase
            if (w == SW_N - 2) chk("fd_before_last", frame_done, 0);
        end
        i_valid = 1'b0;
        chk("f1_done", frame_done, 1);
        chk("f1_cnt", det_cnt, 3);
        chk("f1_bvalid", best_valid, 1);
        chk("f1_bres", best_result, 9);
        chk("f1_bid", best_sw_id, 20);
        step();
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_cnt_hold", det_cnt, 3);

        // ---- out-of-range index is an ordinary window ----
        win(-5, 2000);
        i_valid = 1'b0;
        chk("oor_no_done", frame_done, 0);

        // ---- frame with nothing above threshold ----
        for (int w = 0; w < SW_N; w++) begin
            win(-5, w);
        end
        i_valid = 1'b0;
        chk("f2_done", frame_done, 1);
        chk("f2_cnt", det_cnt, 0);
        chk("f2_bvalid", best_valid, 0);
        chk("f2_bres", best_result, 0);
        chk("f2_bid", best_sw_id, 0);

        // ---- async reset mid-frame with 5 queued ----
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            win(50 + k, 100 + k);
        end
        i_valid = 1'b0;
        chk("pre_rst_vld", o_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_vld", o_valid, 0);
        chk("async_rst_ovf", overflow, 0);
        #2;
        rst = 1'b1;
        step();
        o_ready = 1'b1;
        win(-5, 1515);
        win(-5, 1516);
        win(4, 1517);
        win(-5, 1518);
        win(-5, 1519);
        i_valid = 1'b0;
        chk("f3_done", frame_done, 1);
        chk("f3_cnt", det_cnt, 1);
        chk("f3_bres", best_result, 4);
        chk("f3_bid", best_sw_id, 1517);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
